axis_packetizer: RTL and testbench

Registered AXI-Stream stage that sits directly downstream of the stream on/off switch. It adds TLAST framing to the 256-bit data stream: a beat counter marks every Nth accepted beat as end-of-packet. It also provides a two-entry skid buffer, so that all handshake outputs come from flops for timing closure toward the downstream consumer.

---
 rtl/axis_packetizer.sv | 136 +++++++++++++
 tb/tb_axis_packetizer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packetizer.sv
// AXI-Stream TLAST framer with a two-entry skid buffer; all TX/RX handshakes are flop-driven.
// Optional AXIS_PKT_STATS_EN adds the PACKETS_SENT counter of TLAST beats delivered.
module axis_packetizer #(
    parameter int DATA_WIDTH = 256,
    parameter int SIZE_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [SIZE_WIDTH-1:0] PACKET_SIZE,
    input  logic [DATA_WIDTH-1:0] AXIS_RX_TDATA,
    input  logic                  AXIS_RX_TVALID,
    output logic                  AXIS_RX_TREADY,
    output logic [DATA_WIDTH-1:0] AXIS_TX_TDATA,
    output logic                  AXIS_TX_TVALID,
    output logic                  AXIS_TX_TLAST,
    input  logic                  AXIS_TX_TREADY
`ifdef AXIS_PKT_STATS_EN
    ,
    output logic [31:0]           PACKETS_SENT
`endif
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                  main_last_q, main_last_d;
    logic                  skid_last_q, skid_last_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  rx_ready_q, rx_ready_d;
    logic [SIZE_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [SIZE_WIDTH-1:0] pkt_len_q, pkt_len_d;
    logic [SIZE_WIDTH-1:0] size_eff, len_now;
    logic                  in_acc, out_acc, beat_last;

    assign in_acc  = AXIS_RX_TVALID && rx_ready_q;
    assign out_acc = tx_valid_q && AXIS_TX_TREADY;

    // The first beat of a packet is judged against the length latched with it
    assign size_eff  = (PACKET_SIZE == '0) ? SIZE_WIDTH'(1) : PACKET_SIZE;
    assign len_now   = (beat_cnt_q == '0) ? size_eff : pkt_len_q;
    assign beat_last = (beat_cnt_q + SIZE_WIDTH'(1)) == len_now;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_last_d = main_last_q;
        skid_data_d = skid_data_q;
        skid_last_d = skid_last_q;
        beat_cnt_d  = beat_cnt_q;
        pkt_len_d   = pkt_len_q;

        if (in_acc) begin
            if (beat_cnt_q == '0) pkt_len_d = size_eff;
            beat_cnt_d = beat_last ? '0 : beat_cnt_q + SIZE_WIDTH'(1);
        end

        unique case (state_q)
            EMPTY: begin
                if (in_acc) begin
                    state_d     = ONE;
                    main_data_d = AXIS_RX_TDATA;
                    main_last_d = beat_last;
                end
            end
            ONE: begin
                if (in_acc && out_acc) begin
                    main_data_d = AXIS_RX_TDATA;
                    main_last_d = beat_last;
                end else if (in_acc) begin
                    state_d     = FULL;
                    skid_data_d = AXIS_RX_TDATA;
                    skid_last_d = beat_last;
                end else if (out_acc) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_acc) begin
                    state_d     = ONE;
                    main_data_d = skid_data_q;
                    main_last_d = skid_last_q;
                end
            end
            default: state_d = EMPTY;
        endcase

        tx_valid_d = (state_d != EMPTY);
        rx_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_last_q <= 1'b0;
            skid_data_q <= '0;
            skid_last_q <= 1'b0;
            tx_valid_q  <= 1'b0;
            rx_ready_q  <= 1'b0;
            beat_cnt_q  <= '0;
            pkt_len_q   <= SIZE_WIDTH'(1);
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_last_q <= main_last_d;
            skid_data_q <= skid_data_d;
            skid_last_q <= skid_last_d;
            tx_valid_q  <= tx_valid_d;
            rx_ready_q  <= rx_ready_d;
            beat_cnt_q  <= beat_cnt_d;
            pkt_len_q   <= pkt_len_d;
        end
    end

    assign AXIS_RX_TREADY = rx_ready_q;
    assign AXIS_TX_TDATA  = main_data_q;
    assign AXIS_TX_TLAST  = main_last_q;
    assign AXIS_TX_TVALID = tx_valid_q;

`ifdef AXIS_PKT_STATS_EN
    logic [31:0] pkt_cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pkt_cnt_q <= '0;
        end else if (out_acc && main_last_q) begin
            pkt_cnt_q <= pkt_cnt_q + 32'd1;
        end
    end

    assign PACKETS_SENT = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_axis_packetizer.sv
// Scoreboard bench for axis_packetizer: directed steps, queue of expected beats.
// Define AXIS_PKT_STATS_EN to also check PACKETS_SENT.
module tb_axis_packetizer;

    localparam int DW = 256;
    localparam int SW = 16;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [SW-1:0] PACKET_SIZE = '0;
    logic [DW-1:0] AXIS_RX_TDATA = '0;
    logic          AXIS_RX_TVALID = 1'b0;
    logic          AXIS_RX_TREADY;
    logic [DW-1:0] AXIS_TX_TDATA;
    logic          AXIS_TX_TVALID;
    logic          AXIS_TX_TLAST;
    logic          AXIS_TX_TREADY = 1'b0;
`ifdef AXIS_PKT_STATS_EN
    logic [31:0]   PACKETS_SENT;
`endif

    axis_packetizer #(.DATA_WIDTH(DW), .SIZE_WIDTH(SW)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .PACKET_SIZE    (PACKET_SIZE),
        .AXIS_RX_TDATA  (AXIS_RX_TDATA),
        .AXIS_RX_TVALID (AXIS_RX_TVALID),
        .AXIS_RX_TREADY (AXIS_RX_TREADY),
        .AXIS_TX_TDATA  (AXIS_TX_TDATA),
        .AXIS_TX_TVALID (AXIS_TX_TVALID),
        .AXIS_TX_TLAST  (AXIS_TX_TLAST),
        .AXIS_TX_TREADY (AXIS_TX_TREADY)
`ifdef AXIS_PKT_STATS_EN
        ,
        .PACKETS_SENT   (PACKETS_SENT)
`endif
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad = 0;
    beat_t q[$];
    int    m_cnt = 0;
    int    m_len = 1;
    int    lasts = 0;
    int    pops = 0;
    logic [DW-1:0] last_tl_data = '0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_data = '0;
    logic          stall_last = 1'b0;
    logic          rnd_on = 1'b0;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: decides at negedge which handshakes complete on the next posedge
    always @(negedge clk) begin
        beat_t b;
        int    len;
        if (!resetn) begin
            stall_prev = 1'b0;
        end else begin
            if (q.size() == 2) chk("ready_low_when_full", DW'(AXIS_RX_TREADY), '0);
            if (stall_prev) begin
                chk("stall_data_stable", AXIS_TX_TDATA, stall_data);
                chk("stall_last_stable", DW'(AXIS_TX_TLAST), DW'(stall_last));
            end
            if (AXIS_TX_TVALID && AXIS_TX_TREADY) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", DW'(1), '0);
                end else begin
                    b = q.pop_front();
                    pops++;
                    chk("tx_data", AXIS_TX_TDATA, b.data);
                    chk("tx_last", DW'(AXIS_TX_TLAST), DW'(b.last));
                    if (b.last) begin
                        lasts++;
                        last_tl_data = b.data;
                    end
                end
            end
            if (AXIS_RX_TVALID && AXIS_RX_TREADY) begin
                if (m_cnt == 0) m_len = (PACKET_SIZE == 0) ? 1 : int'(PACKET_SIZE);
                m_cnt++;
                b.data = AXIS_RX_TDATA;
                b.last = (m_cnt == m_len);
                if (b.last) m_cnt = 0;
                q.push_back(b);
            end
            stall_prev = AXIS_TX_TVALID && !AXIS_TX_TREADY;
            stall_data = AXIS_TX_TDATA;
            stall_last = AXIS_TX_TLAST;
        end
    end

    task automatic send(input logic [DW-1:0] d);
        int   n;
        logic a;
        n = 0;
        AXIS_RX_TDATA  = d;
        AXIS_RX_TVALID = 1'b1;
        forever begin
            @(negedge clk);
            a = AXIS_RX_TREADY;
            @(posedge clk);
            #1;
            if (a) break;
            n++;
            if (n > 500) begin
                chk("send_timeout", DW'(n), '0);
                break;
            end
        end
    endtask

    task automatic drain();
        int n;
        AXIS_RX_TVALID = 1'b0;
        AXIS_TX_TREADY = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain_empty", DW'(q.size()), '0);
        chk("drain_tvalid", DW'(AXIS_TX_TVALID), '0);
    endtask

    initial begin
        int lasts0, acc;
        #1;
        chk("rst_tvalid", DW'(AXIS_TX_TVALID), '0);
        chk("rst_tlast", DW'(AXIS_TX_TLAST), '0);
        chk("rst_tdata", AXIS_TX_TDATA, '0);
        chk("rst_rready", DW'(AXIS_RX_TREADY), '0);
`ifdef AXIS_PKT_STATS_EN
        chk("rst_pkts", DW'(PACKETS_SENT), '0);
`endif
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        chk("rready_before_edge", DW'(AXIS_RX_TREADY), '0);
        @(posedge clk);
        #1;
        chk("rready_after_edge", DW'(AXIS_RX_TREADY), DW'(1));

        // 4-beat packets at full rate
        PACKET_SIZE = 4;
        AXIS_TX_TREADY = 1'b1;
        for (int i = 1; i <= 12; i++) send(DW'(i));
        drain();
        chk("t1_lasts", DW'(lasts), DW'(3));
        chk("t1_last_data", last_tl_data, DW'(12));
`ifdef AXIS_PKT_STATS_EN
        chk("t1_pkts", DW'(PACKETS_SENT), DW'(3));
`endif

        // size 0 acts as 1
        PACKET_SIZE = 0;
        lasts0 = lasts;
        for (int i = 0; i < 3; i++) send(DW'(32'h100 + i));
        drain();
        chk("t2_lasts", DW'(lasts - lasts0), DW'(3));

        // random handshakes, 3-beat packets
        PACKET_SIZE = 3;
        lasts0 = lasts;
        rnd_on = 1'b1;
        fork
            while (rnd_on) begin
                @(posedge clk);
                #1;
                AXIS_TX_TREADY = 1'($urandom_range(0, 1));
            end
        join_none
        for (int i = 0; i < 999; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                AXIS_RX_TVALID = 1'b0;
                @(posedge clk);
                #1;
            end
            send({$urandom, $urandom, $urandom, DW'(i)} );
        end
        AXIS_RX_TVALID = 1'b0;
        rnd_on = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        drain();
        chk("t3_lasts", DW'(lasts - lasts0), DW'(333));

        // size change mid-packet takes effect on the next packet
        PACKET_SIZE = 4;
        lasts0 = lasts;
        send(DW'(32'h201));
        send(DW'(32'h202));
        PACKET_SIZE = 2;
        for (int i = 3; i <= 8; i++) send(DW'(32'h200 + i));
        drain();
        chk("t4_lasts", DW'(lasts - lasts0), DW'(3));
        chk("t4_last_data", last_tl_data, DW'(32'h208));

        // reset with two beats buffered mid-packet
        PACKET_SIZE = 4;
        AXIS_TX_TREADY = 1'b0;
        send(DW'(32'h301));
        send(DW'(32'h302));
        AXIS_RX_TVALID = 1'b0;
        resetn = 1'b0;
        #1;
        chk("t5_rst_tvalid", DW'(AXIS_TX_TVALID), '0);
        chk("t5_rst_rready", DW'(AXIS_RX_TREADY), '0);
        q.delete();
        m_cnt = 0;
        @(posedge clk);
        #1;
        chk("t5_hold_tvalid", DW'(AXIS_TX_TVALID), '0);
        resetn = 1'b1;
        AXIS_TX_TREADY = 1'b1;
        lasts0 = lasts;
        for (int i = 1; i <= 4; i++) send(DW'(32'h310 + i));
        drain();
        chk("t5_lasts", DW'(lasts - lasts0), DW'(1));
        chk("t5_last_data", last_tl_data, DW'(32'h314));

        // long stall: exactly two beats absorbed
        AXIS_TX_TREADY = 1'b0;
        AXIS_RX_TDATA = DW'(32'h400);
        AXIS_RX_TVALID = 1'b1;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            logic a;
            @(negedge clk);
            a = AXIS_RX_TREADY;
            @(posedge clk);
            #1;
            if (a) begin
                acc++;
                AXIS_RX_TDATA = AXIS_RX_TDATA + DW'(1);
            end
        end
        AXIS_RX_TVALID = 1'b0;
        chk("t6_accepted", DW'(acc), DW'(2));
        chk("t6_rready", DW'(AXIS_RX_TREADY), '0);
        drain();
        chk("t6_pops_total", DW'(pops), DW'(12 + 3 + 999 + 8 + 4 + 2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        chk("global_timeout", DW'(1), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "FAIL global_timeout");
    end

endmodule
